// File: rtl/i2s_pkg.sv
// Shared types and helper functions for the I2S/TDM slave serial-audio transceiver.
package i2s_pkg;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        START = 2'd1,
        MID   = 2'd2
    } ws_edge_e;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_EARLY_SYNC   = 2'd1,
        ERR_MISSING_SYNC = 2'd2,
        ERR_MID_EDGE     = 2'd3
    } err_cause_e;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_e;

    function automatic int frame_bits(input int n_ch, input int slot_w);
        return n_ch * slot_w;
    endfunction

    // Index into the lane-packed frame vector of the bit at frame position pos; -1 for pad bits.
    function automatic int lane_bit(input int pos, input int slot_w, input int data_w);
        int off;
        off = pos % slot_w;
        if (off < data_w) begin
            return (pos / slot_w) * data_w + (data_w - 1 - off);
        end else begin
            return -1;
        end
    endfunction

endpackage

// File: rtl/i2s_slot_counter.sv
// Frame position counter, WS edge detection, lock tracking and framing-error detection.
module i2s_slot_counter
    import i2s_pkg::*;
#(
    parameter int SLOT_W   = 16,
    parameter int N_CH     = 2,
    parameter int WS_START = 0,
    parameter int POS_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ws,
    output logic [POS_W-1:0] pos,
    output logic [POS_W-1:0] next_pos,
    output logic             start_edge,
    output logic             frame_err,
    output logic             frame_done,
    output logic             locked
);
    localparam int               FRAME_BITS = frame_bits(N_CH, SLOT_W);
    localparam logic [POS_W-1:0] LAST_POS   = POS_W'(FRAME_BITS - 1);
    localparam logic [POS_W-1:0] MID_POS    = POS_W'(SLOT_W - 1);
    localparam logic             WS_LVL     = (WS_START != 0) ? 1'b1 : 1'b0;
    localparam logic             CHECK_MID  = (N_CH == 2) ? 1'b1 : 1'b0;

    logic        ws_q;
    ws_edge_e    edge_kind;
    err_cause_e  cause;
    lock_state_e state;
    lock_state_e next_state;

    // WS history and frame position register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ws_q <= WS_LVL;
            pos  <= LAST_POS;
        end else begin
            ws_q <= ws;
            pos  <= next_pos;
        end
    end

    // Lock state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= UNLOCKED;
        end else begin
            state <= next_state;
        end
    end

    // Classify the WS transition seen at this edge.
    always_comb begin
        edge_kind = NONE;
        if (ws != ws_q) begin
            if (ws == WS_LVL) begin
                edge_kind = START;
            end else begin
                edge_kind = MID;
            end
        end else begin
            edge_kind = NONE;
        end
    end

    // A start edge realigns the counter; otherwise it free-runs and wraps.
    always_comb begin
        next_pos = pos;
        if (edge_kind == START) begin
            next_pos = '0;
        end else if (pos == LAST_POS) begin
            next_pos = '0;
        end else begin
            next_pos = pos + POS_W'(1);
        end
    end

    // Lock transitions: any start edge locks, any error unlocks.
    always_comb begin
        next_state = state;
        case (state)
            UNLOCKED: begin
                if (edge_kind == START) begin
                    next_state = LOCKED;
                end else begin
                    next_state = UNLOCKED;
                end
            end
            LOCKED: begin
                if (cause != ERR_NONE) begin
                    next_state = UNLOCKED;
                end else begin
                    next_state = LOCKED;
                end
            end
            default: next_state = UNLOCKED;
        endcase
    end

    // Error causes are only meaningful while the frame timing is tracked.
    always_comb begin
        cause = ERR_NONE;
        if (state == LOCKED) begin
            if (edge_kind == START && pos != LAST_POS) begin
                cause = ERR_EARLY_SYNC;
            end else if (edge_kind != START && pos == LAST_POS) begin
                cause = ERR_MISSING_SYNC;
            end else if (CHECK_MID && edge_kind == MID && pos != MID_POS) begin
                cause = ERR_MID_EDGE;
            end else begin
                cause = ERR_NONE;
            end
        end else begin
            cause = ERR_NONE;
        end
        locked     = (state == LOCKED);
        start_edge = (edge_kind == START);
        frame_err  = (cause != ERR_NONE);
        frame_done = (state == LOCKED) && (edge_kind == START) && (cause == ERR_NONE);
    end

endmodule

// File: rtl/i2s_tdm_transceiver.sv
// Slave I2S/TDM port: deserialises N_CH lanes from sdata_i, serialises N_CH lanes to sdata_o.
module i2s_tdm_transceiver
    import i2s_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int SLOT_W   = 16,
    parameter int N_CH     = 2,
    parameter int WS_START = 0
) (
    input  logic                   sclk_i,
    input  logic                   rst_i,
    input  logic                   ws_i,
    input  logic                   sdata_i,
    input  logic [N_CH*DATA_W-1:0] tx_data_i,
    output logic                   sdata_o,
    output logic [N_CH*DATA_W-1:0] rx_data_o,
    output logic                   rx_valid_o,
    output logic                   tx_load_o,
    output logic                   locked_o,
    output logic                   frame_err_o,
    output logic                   err_sticky_o
);
    localparam int FRAME_W = N_CH * DATA_W;
    localparam int POS_W   = $clog2(frame_bits(N_CH, SLOT_W));
    localparam int IDX_W   = $clog2(FRAME_W);

    logic [POS_W-1:0]   pos;
    logic [POS_W-1:0]   next_pos;
    logic               start_edge;
    logic               frame_err;
    logic               frame_done;
    logic [FRAME_W-1:0] rx_frame;
    logic [FRAME_W-1:0] rx_asm;
    logic [FRAME_W-1:0] tx_frame;
    logic [FRAME_W-1:0] tx_src;
    logic               tx_bit;
    int                 rx_lane;
    int                 tx_lane;

    i2s_slot_counter #(
        .SLOT_W   (SLOT_W),
        .N_CH     (N_CH),
        .WS_START (WS_START),
        .POS_W    (POS_W)
    ) u_counter (
        .clk        (sclk_i),
        .rst        (rst_i),
        .ws         (ws_i),
        .pos        (pos),
        .next_pos   (next_pos),
        .start_edge (start_edge),
        .frame_err  (frame_err),
        .frame_done (frame_done),
        .locked     (locked_o)
    );

    // Merge the bit sampled now so the last slot's final bit is part of a frame completed at this edge.
    always_comb begin
        rx_lane = lane_bit(int'(pos), SLOT_W, DATA_W);
        rx_asm  = rx_frame;
        if (rx_lane >= 0) begin
            rx_asm[IDX_W'(rx_lane)] = sdata_i;
        end else begin
            rx_asm = rx_frame;
        end
    end

    // At a start edge the new tx frame is used directly so ch0 MSB leaves on the same edge.
    always_comb begin
        tx_src  = start_edge ? tx_data_i : tx_frame;
        tx_lane = lane_bit(int'(next_pos), SLOT_W, DATA_W);
        if (tx_lane >= 0) begin
            tx_bit = tx_src[IDX_W'(tx_lane)];
        end else begin
            tx_bit = 1'b0;
        end
    end

    // Shift state and registered outputs.
    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            rx_frame     <= '0;
            tx_frame     <= '0;
            sdata_o      <= 1'b0;
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            tx_load_o    <= 1'b0;
            frame_err_o  <= 1'b0;
            err_sticky_o <= 1'b0;
        end else begin
            rx_frame     <= rx_asm;
            sdata_o      <= tx_bit;
            tx_load_o    <= start_edge;
            rx_valid_o   <= frame_done;
            frame_err_o  <= frame_err;
            err_sticky_o <= err_sticky_o | frame_err;
            if (start_edge) begin
                tx_frame <= tx_data_i;
            end else begin
                tx_frame <= tx_frame;
            end
            if (frame_done) begin
                rx_data_o <= rx_asm;
            end else begin
                rx_data_o <= rx_data_o;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tdm_transceiver.sv
// Directed-sequence bench with random payloads for the I2S (2x16) and TDM (8x24 in 32) configurations.
`timescale 1ns/1ps
module tb_i2s_tdm_transceiver;
    localparam int FB   = 32;
    localparam int T_FB = 256;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, ws, sdi, sdo, rxv, txl, lck, ferr, stk;
    logic [31:0]  txd, rxd;
    logic         t_rst, t_ws, t_sdi, t_sdo, t_rxv, t_txl, t_lck, t_ferr, t_stk;
    logic [191:0] t_txd, t_rxd;

    i2s_tdm_transceiver dut (
        .sclk_i(clk), .rst_i(rst), .ws_i(ws), .sdata_i(sdi), .tx_data_i(txd),
        .sdata_o(sdo), .rx_data_o(rxd), .rx_valid_o(rxv), .tx_load_o(txl),
        .locked_o(lck), .frame_err_o(ferr), .err_sticky_o(stk)
    );

    i2s_tdm_transceiver #(.DATA_W(24), .SLOT_W(32), .N_CH(8), .WS_START(1)) dut_tdm (
        .sclk_i(clk), .rst_i(t_rst), .ws_i(t_ws), .sdata_i(t_sdi), .tx_data_i(t_txd),
        .sdata_o(t_sdo), .rx_data_o(t_rxd), .rx_valid_o(t_rxv), .tx_load_o(t_txl),
        .locked_o(t_lck), .frame_err_o(t_ferr), .err_sticky_o(t_stk)
    );

    int             n_tests = 0;
    int             n_fail  = 0;
    int             c_valid, c_err, c_load;
    bit             loop;
    logic [FB-1:0]  cap;
    logic [T_FB-1:0] t_cap;
    logic [31:0]    w, prev, lat;
    logic [191:0]   t_exp;
    logic           pad_or;

    task automatic chk_i(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_w(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line image of a frame: each lane MSB-first, then its pad bits as zeros; bit p = frame position p.
    function automatic logic [255:0] serialise(input logic [255:0] lanes, input int dw, input int sw, input int nch);
        logic [255:0] s;
        int p;
        s = '0;
        p = 0;
        for (int ch = 0; ch < nch; ch++) begin
            for (int b = dw - 1; b >= 0; b--) begin
                s[p] = lanes[ch*dw + b];
                p++;
            end
            p += sw - dw;
        end
        return s;
    endfunction

    // mode 0: standard I2S ws, 1: force start level on the last driven bit, 2: hold ws static
    task automatic frame(input logic [31:0] lanes, input int len, input int mode);
        logic [255:0] line;
        logic         lvl;
        logic         wl;
        line    = serialise({224'd0, lanes}, 16, 16, 2);
        lvl     = ws;
        c_valid = 0;
        c_err   = 0;
        c_load  = 0;
        for (int j = 0; j < len; j++) begin
            if (mode == 2) wl = lvl;
            else if (mode == 1 && j == len - 1) wl = 1'b0;
            else wl = (((j + 1) % FB) >= 16) ? 1'b1 : 1'b0;
            @(negedge clk);
            ws  = wl;
            sdi = loop ? sdo : line[j];
            @(posedge clk);
            #1;
            c_valid += int'(rxv);
            c_err   += int'(ferr);
            c_load  += int'(txl);
            cap[(j + 1) % FB] = sdo;
        end
    endtask

    task automatic t_frame(input logic [191:0] lanes);
        logic [255:0] line;
        line    = serialise({64'd0, lanes}, 24, 32, 8);
        c_valid = 0;
        c_err   = 0;
        for (int j = 0; j < T_FB; j++) begin
            @(negedge clk);
            t_ws  = (j == T_FB - 1) ? 1'b1 : 1'b0;
            t_sdi = ((j % 32) >= 24) ? 1'($urandom) : line[j];
            @(posedge clk);
            #1;
            c_valid += int'(t_rxv);
            c_err   += int'(t_ferr);
            t_cap[(j + 1) % T_FB] = t_sdo;
        end
    endtask

    initial begin
        rst = 1'b1; ws = 1'b0; sdi = 1'b0; txd = '0; loop = 1'b0;
        t_rst = 1'b1; t_ws = 1'b0; t_sdi = 1'b0; t_txd = '0;

        // 1. reset, lock, then standard I2S frames
        repeat (4) @(posedge clk);
        #1;
        chk_w("reset_outputs", 256'({rxd, rxv, txl, lck, ferr, stk, sdo}), 256'd0);
        rst = 1'b0;
        frame(32'hBEEF_DEAD, FB, 0);
        chk_i("t1_lock_no_valid", c_valid, 0);
        chk_i("t1_locked", int'(lck), 1);
        chk_i("t1_lock_no_err", c_err, 0);
        frame(32'hBEEF_DEAD, FB, 0);
        chk_w("t1_rx_data", 256'(rxd), 256'(32'hBEEF_DEAD));
        chk_i("t1_valid_now", int'(rxv), 1);
        chk_i("t1_valid_count", c_valid, 1);
        for (int i = 0; i < 4; i++) begin
            w = $urandom;
            frame(w, FB, 0);
            chk_w("t1_rand_rx", 256'(rxd), 256'(w));
            chk_i("t1_rand_valid_count", c_valid, 1);
            chk_i("t1_rand_no_err", c_err, 0);
        end

        // 2. loopback: received frame equals the frame latched at the previous start edge
        loop = 1'b1;
        txd  = 32'hDEAD_BEEF;
        frame(32'd0, FB, 0);
        chk_i("t2_tx_load_now", int'(txl), 1);
        prev = txd;
        for (int i = 0; i < 4; i++) begin
            txd = $urandom;
            frame(32'd0, FB, 0);
            chk_w("t2_loop_rx", 256'(rxd), 256'(prev));
            chk_i("t2_tx_load_now", int'(txl), 1);
            chk_i("t2_tx_load_count", c_load, 1);
            prev = txd;
        end

        // 3. early start edge at pos 20
        loop = 1'b0;
        txd  = $urandom;
        lat  = txd;
        frame($urandom, 21, 1);
        chk_i("t3_err_pulse", int'(ferr), 1);
        chk_i("t3_err_count", c_err, 1);
        chk_i("t3_unlocked", int'(lck), 0);
        chk_i("t3_no_valid", c_valid, 0);
        chk_i("t3_sticky", int'(stk), 1);
        chk_i("t3_tx_load_unlocked", int'(txl), 1);
        frame($urandom, FB, 0);
        chk_i("t3_relock", int'(lck), 1);
        chk_i("t3_relock_no_valid", c_valid, 0);
        w = $urandom;
        frame(w, FB, 0);
        chk_w("t3_rx_after_relock", 256'(rxd), 256'(w));
        chk_i("t3_valid_after_relock", c_valid, 1);
        chk_i("t3_sticky_held", int'(stk), 1);

        // 5. ws static while locked: sync missed, tx keeps cycling the latched frame
        frame(32'd0, FB, 2);
        chk_i("t5_missing_sync_err", c_err, 1);
        chk_i("t5_err_at_frame_end", int'(ferr), 1);
        chk_i("t5_unlocked", int'(lck), 0);
        chk_i("t5_no_valid", c_valid, 0);
        chk_w("t5_tx_cycle_1", 256'(cap), serialise({224'd0, lat}, 16, 16, 2));
        frame(32'd0, FB, 2);
        chk_w("t5_tx_cycle_2", 256'(cap), serialise({224'd0, lat}, 16, 16, 2));
        chk_i("t5_no_load", c_load, 0);
        frame($urandom, FB, 0);
        chk_i("t5_relock", int'(lck), 1);
        w = $urandom;
        frame(w, FB, 0);
        chk_w("t5_rx_after_relock", 256'(rxd), 256'(w));

        // 6. reset in the middle of slot 1
        frame($urandom, 20, 0);
        @(negedge clk);
        rst = 1'b1;
        ws  = 1'b1;
        @(posedge clk);
        #1;
        chk_w("t6_reset_outputs", 256'({rxd, rxv, txl, lck, ferr, stk, sdo}), 256'd0);
        rst = 1'b0;
        ws  = 1'b0;
        frame($urandom, FB, 0);
        chk_i("t6_relock_no_valid", c_valid, 0);
        chk_i("t6_relock", int'(lck), 1);
        w = $urandom;
        frame(w, FB, 0);
        chk_w("t6_rx_after_reset", 256'(rxd), 256'(w));
        chk_i("t6_valid_count", c_valid, 1);

        // 4. TDM: 8 x 24-bit lanes in 32-bit slots, one-bit sync pulse
        for (int k = 0; k < 8; k++) t_exp[k*24 +: 24] = 24'h100000 + 24'(k);
        for (int k = 0; k < 6; k++) t_txd[k*32 +: 32] = $urandom;
        #1;
        chk_w("t4_reset_outputs", 256'({t_rxd, t_rxv, t_txl, t_lck, t_ferr, t_stk, t_sdo}), 256'd0);
        t_rst = 1'b0;
        t_frame(t_exp);
        chk_i("t4_locked", int'(t_lck), 1);
        chk_i("t4_lock_no_valid", c_valid, 0);
        t_frame(t_exp);
        chk_w("t4_rx_lanes", 256'(t_rxd), 256'(t_exp));
        chk_i("t4_valid_count", c_valid, 1);
        chk_i("t4_no_err", c_err, 0);
        chk_w("t4_tx_line", 256'(t_cap), serialise({64'd0, t_txd}, 24, 32, 8));
        pad_or = 1'b0;
        for (int p = 0; p < T_FB; p++) begin
            if ((p % 32) >= 24) pad_or = pad_or | t_cap[p];
        end
        chk_i("t4_tx_pad_zero", int'(pad_or), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
